// File: rtl/frame_sequencer_if.sv
// Control and raster-output bundle between frame_sequencer (slave) and the
// controller/pipeline that drives it (master).
interface frame_sequencer_if;
  logic       Start;
  logic       Stop;
  logic [7:0] NumFrames;
  logic       Hold;
  logic       PixelReq;
  logic       Frame;
  logic       Line;
  logic [7:0] i;
  logic [7:0] j;
  logic       Busy;
  logic       Done;
  logic [7:0] FrameCount;

  modport master (
    output Start, Stop, NumFrames, Hold,
    input  PixelReq, Frame, Line, i, j, Busy, Done, FrameCount
  );

  modport slave (
    input  Start, Stop, NumFrames, Hold,
    output PixelReq, Frame, Line, i, j, Busy, Done, FrameCount
  );
endinterface

// File: rtl/frame_sequencer.sv
// Raster timing controller: one pixel request per unstalled cycle over a
// WIDTH x HEIGHT frame with horizontal/vertical blanking, under Start/Stop/Hold.
module frame_sequencer #(
  parameter int WIDTH  = 64,
  parameter int HEIGHT = 64,
  parameter int HBLANK = 4,
  parameter int VBLANK = 16
) (
  input logic              Clk,
  input logic              nReset,
  frame_sequencer_if.slave bus
);
  localparam logic [7:0]  LastCol   = 8'(WIDTH - 1);
  localparam logic [7:0]  LastRow   = 8'(HEIGHT - 1);
  localparam logic [15:0] HBlankLen = 16'(HBLANK);
  localparam logic [15:0] VBlankLen = 16'(VBLANK);

  // The state names what the next unstalled edge produces; col/row point at the next pixel.
  typedef enum logic [1:0] {StIdle, StActive, StHBlank, StVBlank} state_t;

  state_t      state, stateNext;
  logic [7:0]  col, colNext, row, rowNext;
  logic [15:0] blankCnt, cntNext;
  logic [7:0]  numLatched, numNext;
  logic        stopLatched, stopNext;
  logic        frameDone, frameDoneNext;
  logic        pixelReq, pixelReqNext, frameOut, frameNext, lineOut, lineNext;
  logic [7:0]  iReg, iNext, jReg, jNext;
  logic        busy, busyNext, done, doneNext;
  logic [7:0]  frameCount, frameCountNext;
  logic        emit;
  logic [7:0]  pc, pr;

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state       <= StIdle;
      col         <= '0;
      row         <= '0;
      blankCnt    <= '0;
      numLatched  <= '0;
      stopLatched <= 1'b0;
      frameDone   <= 1'b0;
      pixelReq    <= 1'b0;
      frameOut    <= 1'b0;
      lineOut     <= 1'b0;
      iReg        <= '0;
      jReg        <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      frameCount  <= '0;
    end else begin
      state       <= stateNext;
      col         <= colNext;
      row         <= rowNext;
      blankCnt    <= cntNext;
      numLatched  <= numNext;
      stopLatched <= stopNext;
      frameDone   <= frameDoneNext;
      pixelReq    <= pixelReqNext;
      frameOut    <= frameNext;
      lineOut     <= lineNext;
      iReg        <= iNext;
      jReg        <= jNext;
      busy        <= busyNext;
      done        <= doneNext;
      frameCount  <= frameCountNext;
    end
  end

  always_comb begin
    stateNext      = state;
    colNext        = col;
    rowNext        = row;
    cntNext        = blankCnt;
    numNext        = numLatched;
    stopNext       = stopLatched;
    frameDoneNext  = 1'b0;
    pixelReqNext   = 1'b0;
    frameNext      = 1'b0;
    lineNext       = 1'b0;
    iNext          = iReg;
    jNext          = jReg;
    busyNext       = busy;
    doneNext       = 1'b0;
    frameCountNext = frameDone ? frameCount + 8'd1 : frameCount;
    emit           = 1'b0;
    pc             = col;
    pr             = row;

    if (state == StIdle) begin
      if (bus.Start) begin
        numNext        = bus.NumFrames;
        stopNext       = 1'b0;
        frameCountNext = '0;
        busyNext       = 1'b1;
        pc             = '0;
        pr             = '0;
        emit           = 1'b1;
      end
    end else begin
      if (bus.Stop) stopNext = 1'b1;
      if (!bus.Hold) begin
        case (state)
          // Pointing at (0,0) while running means a frame boundary: end here or start the next frame.
          StActive: begin
            if (col == 8'd0 && row == 8'd0 &&
                (stopNext || (numLatched != 8'd0 && frameCountNext == numLatched))) begin
              stateNext = StIdle;
              busyNext  = 1'b0;
              doneNext  = 1'b1;
              stopNext  = 1'b0;
            end else begin
              emit = 1'b1;
            end
          end
          StHBlank, StVBlank: begin
            if (blankCnt == 16'd1) stateNext = StActive;
            else                   cntNext   = blankCnt - 16'd1;
          end
          default: stateNext = StIdle;
        endcase
      end
    end

    if (emit) begin
      pixelReqNext = 1'b1;
      iNext        = pc;
      jNext        = pr;
      lineNext     = (pc == 8'd0);
      frameNext    = (pc == 8'd0) && (pr == 8'd0);
      if (pc != LastCol) begin
        stateNext = StActive;
        colNext   = pc + 8'd1;
        rowNext   = pr;
      end else if (pr != LastRow) begin
        colNext = '0;
        rowNext = pr + 8'd1;
        if (HBLANK == 0) begin
          stateNext = StActive;
        end else begin
          stateNext = StHBlank;
          cntNext   = HBlankLen;
        end
      end else begin
        frameDoneNext = 1'b1;
        colNext       = '0;
        rowNext       = '0;
        if (VBLANK == 0) begin
          stateNext = StActive;
        end else begin
          stateNext = StVBlank;
          cntNext   = VBlankLen;
        end
      end
    end
  end

  assign bus.PixelReq   = pixelReq;
  assign bus.Frame      = frameOut;
  assign bus.Line       = lineOut;
  assign bus.i          = iReg;
  assign bus.j          = jReg;
  assign bus.Busy       = busy;
  assign bus.Done       = done;
  assign bus.FrameCount = frameCount;
endmodule

// File: tb/tb_frame_sequencer.sv
// Scoreboard bench for frame_sequencer: three geometries, hand-timed expected events
// queued per instance and consumed by a monitor whenever a DUT strobes an output.
module tb_frame_sequencer;
  typedef struct packed {
    logic [15:0] cyc;
    logic        pix;
    logic        frm;
    logic        lin;
    logic        dn;
    logic        busy;
    logic [7:0]  i;
    logic [7:0]  j;
    logic [7:0]  fc;
  } ev_t;

  logic       Clk = 1'b0;
  logic       nReset;
  logic [2:0] startV, stopV, holdV;
  logic [7:0] numV [3];
  int         cyc = 0;
  int         baseCyc [3];
  ev_t        expQ [3][$];
  int         total = 0;
  int         bad = 0;

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  frame_sequencer_if bus0 ();
  frame_sequencer_if bus1 ();
  frame_sequencer_if bus2 ();

  assign bus0.Start = startV[0];
  assign bus0.Stop = stopV[0];
  assign bus0.Hold = holdV[0];
  assign bus0.NumFrames = numV[0];
  assign bus1.Start = startV[1];
  assign bus1.Stop = stopV[1];
  assign bus1.Hold = holdV[1];
  assign bus1.NumFrames = numV[1];
  assign bus2.Start = startV[2];
  assign bus2.Stop = stopV[2];
  assign bus2.Hold = holdV[2];
  assign bus2.NumFrames = numV[2];

  frame_sequencer #(.WIDTH(4), .HEIGHT(2), .HBLANK(2), .VBLANK(3)) dut0 (
    .Clk(Clk), .nReset(nReset), .bus(bus0));
  frame_sequencer #(.WIDTH(4), .HEIGHT(2), .HBLANK(0), .VBLANK(0)) dut1 (
    .Clk(Clk), .nReset(nReset), .bus(bus1));
  frame_sequencer #(.WIDTH(1), .HEIGHT(1), .HBLANK(0), .VBLANK(0)) dut2 (
    .Clk(Clk), .nReset(nReset), .bus(bus2));

  task automatic pushPix(input int g, input int c, input int i, input int j, input int fc);
    ev_t e;
    e.cyc = 16'(c);
    e.pix = 1'b1;
    e.frm = (i == 0) && (j == 0);
    e.lin = (i == 0);
    e.dn = 1'b0;
    e.busy = 1'b1;
    e.i = 8'(i);
    e.j = 8'(j);
    e.fc = 8'(fc);
    expQ[g].push_back(e);
  endtask

  task automatic pushRow(input int g, input int c, input int j, input int w, input int fc);
    for (int k = 0; k < w; k++) pushPix(g, c + k, k, j, fc);
  endtask

  task automatic pushDone(input int g, input int c, input int i, input int j, input int fc);
    ev_t e;
    e.cyc = 16'(c);
    e.pix = 1'b0;
    e.frm = 1'b0;
    e.lin = 1'b0;
    e.dn = 1'b1;
    e.busy = 1'b0;
    e.i = 8'(i);
    e.j = 8'(j);
    e.fc = 8'(fc);
    expQ[g].push_back(e);
  endtask

  task automatic checkOutput(input int g, input logic pix, input logic frm, input logic lin,
                             input logic dn, input logic busy, input logic [7:0] i,
                             input logic [7:0] j, input logic [7:0] fc);
    ev_t act, exp;
    if (!(pix || frm || lin || dn)) return;
    act = {16'(cyc - baseCyc[g]), pix, frm, lin, dn, busy, i, j, fc};
    total++;
    if (expQ[g].size() == 0) begin
      bad++;
      $display("[TB] FAIL inst%0d unexpected: got cyc=%0d pix=%b frm=%b lin=%b done=%b i=%0d j=%0d fc=%0d, required no event",
               g, act.cyc, act.pix, act.frm, act.lin, act.dn, act.i, act.j, act.fc);
      return;
    end
    exp = expQ[g].pop_front();
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL inst%0d event: got cyc=%0d pix=%b frm=%b lin=%b done=%b busy=%b i=%0d j=%0d fc=%0d, required cyc=%0d pix=%b frm=%b lin=%b done=%b busy=%b i=%0d j=%0d fc=%0d",
               g, act.cyc, act.pix, act.frm, act.lin, act.dn, act.busy, act.i, act.j, act.fc,
               exp.cyc, exp.pix, exp.frm, exp.lin, exp.dn, exp.busy, exp.i, exp.j, exp.fc);
    end
  endtask

  task automatic monitorLoop();
    forever begin
      @(negedge Clk);
      if (nReset) begin
        checkOutput(0, bus0.PixelReq, bus0.Frame, bus0.Line, bus0.Done, bus0.Busy, bus0.i, bus0.j, bus0.FrameCount);
        checkOutput(1, bus1.PixelReq, bus1.Frame, bus1.Line, bus1.Done, bus1.Busy, bus1.i, bus1.j, bus1.FrameCount);
        checkOutput(2, bus2.PixelReq, bus2.Frame, bus2.Line, bus2.Done, bus2.Busy, bus2.i, bus2.j, bus2.FrameCount);
      end
    end
  endtask

  // Called at a negedge: Start is sampled at the next posedge (edge 0 of the run).
  task automatic applyStimulus(input int g, input int n);
    baseCyc[g] = cyc;
    startV[g] = 1'b1;
    numV[g] = 8'(n);
    @(negedge Clk);
    startV[g] = 1'b0;
  endtask

  task automatic atCycle(input int g, input int n);
    while (cyc - baseCyc[g] < n) @(negedge Clk);
  endtask

  task automatic waitDrain(input int g, input int limit, input string name);
    int n = 0;
    while (expQ[g].size() != 0 && n < limit) begin
      @(negedge Clk);
      n++;
    end
    repeat (4) @(negedge Clk);
    total++;
    if (expQ[g].size() != 0) begin
      bad++;
      $display("[TB] FAIL %s drain: got %0d events outstanding, required 0", name, expQ[g].size());
      expQ[g].delete();
    end
  endtask

  task automatic checkZero(input string name, input logic [36:0] outs);
    total++;
    if (outs !== '0) begin
      bad++;
      $display("[TB] FAIL %s: got outputs=%h, required 0", name, outs);
    end
  endtask

  initial begin
    startV = '0;
    stopV = '0;
    holdV = '0;
    for (int g = 0; g < 3; g++) begin
      numV[g] = '0;
      baseCyc[g] = 0;
    end
    nReset = 1'b0;
    fork
      monitorLoop();
    join_none
    repeat (3) @(negedge Clk);
    checkZero("reset0", {bus0.PixelReq, bus0.Frame, bus0.Line, bus0.i, bus0.j, bus0.Busy, bus0.Done, bus0.FrameCount});
    checkZero("reset1", {bus1.PixelReq, bus1.Frame, bus1.Line, bus1.i, bus1.j, bus1.Busy, bus1.Done, bus1.FrameCount});
    checkZero("reset2", {bus2.PixelReq, bus2.Frame, bus2.Line, bus2.i, bus2.j, bus2.Busy, bus2.Done, bus2.FrameCount});
    nReset = 1'b1;
    repeat (2) @(negedge Clk);

    $display("[TB] single frame 4x2, hblank 2, vblank 3");
    pushRow(0, 1, 0, 4, 0);
    pushRow(0, 7, 1, 4, 0);
    pushDone(0, 14, 3, 1, 1);
    applyStimulus(0, 1);
    waitDrain(0, 40, "single");

    $display("[TB] single frame with Hold on edges 2-4");
    pushPix(0, 1, 0, 0, 0);
    pushPix(0, 2, 1, 0, 0);
    pushPix(0, 6, 2, 0, 0);
    pushPix(0, 7, 3, 0, 0);
    pushRow(0, 10, 1, 4, 0);
    pushDone(0, 17, 3, 1, 1);
    applyStimulus(0, 1);
    atCycle(0, 2);
    holdV[0] = 1'b1;
    atCycle(0, 5);
    holdV[0] = 1'b0;
    waitDrain(0, 40, "hold");

    $display("[TB] continuous run stopped in cycle 16");
    pushRow(0, 1, 0, 4, 0);
    pushRow(0, 7, 1, 4, 0);
    pushRow(0, 14, 0, 4, 1);
    pushRow(0, 20, 1, 4, 1);
    pushDone(0, 27, 3, 1, 2);
    applyStimulus(0, 0);
    atCycle(0, 16);
    stopV[0] = 1'b1;
    @(negedge Clk);
    stopV[0] = 1'b0;
    waitDrain(0, 40, "continuous");

    $display("[TB] zero blanking, two frames");
    pushRow(1, 1, 0, 4, 0);
    pushRow(1, 5, 1, 4, 0);
    pushRow(1, 9, 0, 4, 1);
    pushRow(1, 13, 1, 4, 1);
    pushDone(1, 17, 3, 1, 2);
    applyStimulus(1, 2);
    waitDrain(1, 40, "noblank");

    $display("[TB] 1x1 frames, back-to-back Start on Done");
    pushPix(2, 1, 0, 0, 0);
    pushPix(2, 2, 0, 0, 1);
    pushPix(2, 3, 0, 0, 2);
    pushDone(2, 4, 0, 0, 3);
    pushPix(2, 5, 0, 0, 0);
    pushDone(2, 6, 0, 0, 1);
    applyStimulus(2, 3);
    atCycle(2, 4);
    startV[2] = 1'b1;
    numV[2] = 8'd1;
    @(negedge Clk);
    startV[2] = 1'b0;
    waitDrain(2, 20, "tiny");

    $display("[TB] Start mid-frame ignored, reset mid-line");
    pushRow(0, 1, 0, 4, 0);
    applyStimulus(0, 1);
    atCycle(0, 2);
    startV[0] = 1'b1;
    numV[0] = 8'd5;
    @(negedge Clk);
    startV[0] = 1'b0;
    atCycle(0, 4);
    #2 nReset = 1'b0;
    #1 checkZero("midreset", {bus0.PixelReq, bus0.Frame, bus0.Line, bus0.i, bus0.j, bus0.Busy, bus0.Done, bus0.FrameCount});
    repeat (2) @(negedge Clk);
    nReset = 1'b1;
    repeat (20) @(negedge Clk);
    waitDrain(0, 4, "abandoned");

    pushRow(0, 1, 0, 4, 0);
    pushRow(0, 7, 1, 4, 0);
    pushDone(0, 14, 3, 1, 1);
    applyStimulus(0, 1);
    waitDrain(0, 40, "restart");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/frame_sequencer.md
Name: frame_sequencer

Overview:
- Raster timing controller that sequences the pixel pipeline (source -> edge filter -> sink).
- Generates per-pixel request, Frame and Line strobes and raster coordinates for a WIDTH x HEIGHT image, with programmable horizontal and vertical blanking.
- Runs a requested number of frames, or runs continuously, under Start/Stop control.
- Supports a downstream Hold (back-pressure) that pauses the raster without skipping or duplicating any pixel.

Parameters:
- WIDTH, 64, active pixels per line (1..256).
- HEIGHT, 64, active lines per frame (1..256).
- HBLANK, 4, idle cycles between lines of one frame (0 allowed).
- VBLANK, 16, idle cycles after the last pixel of a frame (0 allowed).

Ports:
- Clk  in  1  system clock, rising edge.
- nReset  in  1  asynchronous, active-low reset.
- Start  in  1  one-cycle request to begin a run; honoured only in IDLE.
- Stop  in  1  request to end the run after the current frame; ignored in IDLE.
- NumFrames  in  8  frames to run, sampled with Start; 0 = continuous.
- Hold  in  1  downstream not ready; pauses sequencing.
- PixelReq  out  1  a pixel at (i,j) is issued this cycle.
- Frame  out  1  high with PixelReq at pixel (0,0) only.
- Line  out  1  high with PixelReq at each pixel (0,j).
- i  out  8  column of the issued pixel.
- j  out  8  row of the issued pixel.
- Busy  out  1  run in progress.
- Done  out  1  one-cycle pulse when a run ends.
- FrameCount  out  8  frames completed in the current/last run.

Behaviour:
- Clock and reset: one clock, Clk. Reset is asynchronous and active-low on nReset.
- Reset: nReset=0 forces IDLE and clears every output to 0 immediately. Applies from any state; an interrupted run is abandoned with no Done pulse.
- All outputs are registered.
- FSM states:
  - IDLE -> ACTIVE: Start=1 at edge k. In cycle k+1: PixelReq=Frame=Line=1, i=0, j=0, Busy=1, FrameCount=0. NumFrames is latched at the same edge.
  - ACTIVE: one pixel per unstalled cycle, i = 0..WIDTH-1.
    - After i=WIDTH-1 with j<HEIGHT-1: go to HBLANK for HBLANK cycles, then ACTIVE with i=0, j+1, Line=1.
    - If HBLANK=0, the next row's first pixel follows immediately.
  - After pixel (WIDTH-1, HEIGHT-1): FrameCount increments (wraps at 256), visible in the following cycle; go to VBLANK for VBLANK cycles (0 = skip VBLANK).
  - End of VBLANK:
    - If Stop was latched, or NumFrames!=0 and FrameCount==NumFrames: go to IDLE; Busy=0 and Done=1 for one cycle.
    - Otherwise go to ACTIVE at (0,0) with Frame=Line=1.
- Stop: latched on any busy cycle and cleared on entering IDLE. The current frame and its VBLANK always complete.
- Start while busy: ignored. Start and Stop together in IDLE: Start honoured, Stop ignored.
- Hold:
  - Hold=1 at an edge freezes state, all counters and the position; PixelReq/Frame/Line are 0 in the following cycle.
  - The frozen pixel is issued on the first edge with Hold=0.
  - Hold stalls HBLANK/VBLANK counting too.
  - Hold is ignored in IDLE.
- i/j hold the last issued values during blanking, stall and IDLE; they are zeroed on Start.
- Invariant: every coordinate is issued exactly once per frame, in raster order, regardless of Hold pattern.
- Done and Start in the same cycle: Done reflects the finished run; the new Start is accepted at that edge because the FSM is in IDLE, giving back-to-back runs.

Test Plan:
- Single frame, WIDTH=4, HEIGHT=2, HBLANK=2, VBLANK=3, NumFrames=1, Start at edge 0 -> row 0 in cycles 1-4 (Frame/Line in cycle 1), blank in 5-6, row 1 in 7-10 (Line in cycle 7), VBLANK in 11-13, Done=1 and Busy=0 in cycle 14, FrameCount=1.
- Continuous (NumFrames=0), same geometry -> Frame repeats every 13 cycles (cycles 1, 14, 27, ...). Stop in cycle 16 -> frame 2 completes, Done in cycle 27, no pixel after cycle 23, FrameCount=2.
- Hold=1 for edges 2-4 in the single-frame test -> no PixelReq in cycles 3-5, pixel (2,0) issued in cycle 6, all later events shifted by 3, all 8 coordinates issued once.
- HBLANK=0, VBLANK=0, NumFrames=2 -> continuous PixelReq for 16 cycles, Line at i=0 each row, Frame in cycles 1 and 9, Done in cycle 17, FrameCount=2.
- Start pulsed mid-frame is ignored; nReset asserted mid-line -> all outputs 0 immediately, no Done. A fresh Start restarts at (0,0) with FrameCount=0.
- NumFrames=3, WIDTH=HEIGHT=1, HBLANK=VBLANK=0 -> PixelReq/Frame/Line in cycles 1, 2, 3, Done in cycle 4; a new Start in cycle 4 gives Frame in cycle 5.
